// File: rtl/wimax_block_sequencer.sv
// Block sequencer for the WiMax transmit chain: cuts a bit-serial payload into
// fixed-size blocks, pulses the randomizer reseed before each block and streams the bits.
module wimax_block_sequencer #(
    parameter int BLOCK_BITS = 96,
    parameter int GAP_CYCLES = 0,
    parameter int NBLK_W     = 8
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NBLK_W-1:0] cfg_nblocks,
    input  logic              src_valid,
    input  logic              src_data,
    output logic              src_ready,
    input  logic              pipe_ready,
    output logic              pipe_load,
    output logic              pipe_enable,
    output logic              pipe_valid,
    output logic              pipe_data,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [6:0]        bit_cnt,
    output logic [NBLK_W-1:0] blk_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [6:0] LAST_BIT = 7'(BLOCK_BITS - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t            state, state_nxt;
    logic [NBLK_W-1:0] nblk_q;
    logic [NBLK_W-1:0] blk_inc;
    logic [7:0]        gap_cnt;
    logic              xfer, last_bit, last_blk, starve, accept_start;

    // Handshake: a source bit moves when src_valid & src_ready are both high at
    // a clk_ref edge; src_ready already folds in pipe_ready, and abort cancels it.
    assign src_ready    = (state == S_STREAM) & pipe_ready;
    assign xfer         = src_ready & src_valid & ~abort;
    assign last_bit     = (bit_cnt == LAST_BIT);
    assign blk_inc      = blk_cnt + NBLK_W'(1);
    assign last_blk     = (nblk_q != '0) && (blk_inc == nblk_q);
    assign starve       = src_ready & ~src_valid & (bit_cnt != 7'd0);
    assign accept_start = (state == S_IDLE) & start & ~abort;
    assign state_dbg    = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept_start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_STREAM;
            S_STREAM: begin
                if (xfer && last_bit) begin
                    if (last_blk)             state_nxt = S_DONE;
                    else if (GAP_CYCLES == 0) state_nxt = S_LOAD;
                    else                      state_nxt = S_GAP;
                end
            end
            S_GAP:    if (gap_cnt == GAP_LAST) state_nxt = S_LOAD;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state       <= S_IDLE;
            nblk_q      <= '0;
            gap_cnt     <= 8'd0;
            pipe_load   <= 1'b0;
            pipe_enable <= 1'b0;
            pipe_valid  <= 1'b0;
            pipe_data   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            bit_cnt     <= 7'd0;
            blk_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            // Status flags follow the state held during the cycle, so each lags by one edge.
            pipe_load   <= (state == S_LOAD) & ~abort;
            done        <= (state == S_DONE) & ~abort;
            busy        <= (state != S_IDLE);
            pipe_enable <= xfer;
            pipe_valid  <= xfer;
            pipe_data   <= xfer & src_data;
            gap_cnt     <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;

            if (accept_start) begin
                nblk_q   <= cfg_nblocks;
                blk_cnt  <= '0;
                bit_cnt  <= 7'd0;
                underrun <= 1'b0;
            end else if (abort && state != S_IDLE) begin
                bit_cnt <= 7'd0;
            end else if (xfer) begin
                if (last_bit) begin
                    bit_cnt <= 7'd0;
                    blk_cnt <= blk_inc;
                end else begin
                    bit_cnt <= bit_cnt + 7'd1;
                end
            end

            if (starve && !abort) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wimax_block_sequencer.sv
// Bench for wimax_block_sequencer: one default instance and one with a 2-cycle gap
// and 2-bit block counter, sharing stimulus; the checked instance is chosen by sel.
module tb_wimax_block_sequencer;

    logic       clk_ref = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_nblocks = 8'd0;
    logic       src_valid = 1'b0;
    logic       src_data = 1'b0;
    logic       pipe_ready = 1'b0;

    logic       a_src_ready, a_load, a_en, a_valid, a_data, a_busy, a_done, a_und;
    logic [6:0] a_bit;
    logic [7:0] a_blk;
    logic [2:0] a_state;
    logic       b_src_ready, b_load, b_en, b_valid, b_data, b_busy, b_done, b_und;
    logic [6:0] b_bit;
    logic [1:0] b_blk;
    logic [2:0] b_state;

    always #5 clk_ref = ~clk_ref;

    wimax_block_sequencer u_dut_a (
        .clk_ref(clk_ref), .rst(rst), .start(start), .abort(abort),
        .cfg_nblocks(cfg_nblocks), .src_valid(src_valid), .src_data(src_data),
        .src_ready(a_src_ready), .pipe_ready(pipe_ready), .pipe_load(a_load),
        .pipe_enable(a_en), .pipe_valid(a_valid), .pipe_data(a_data), .busy(a_busy),
        .done(a_done), .underrun(a_und), .bit_cnt(a_bit), .blk_cnt(a_blk),
        .state_dbg(a_state)
    );

    wimax_block_sequencer #(.BLOCK_BITS(96), .GAP_CYCLES(2), .NBLK_W(2)) u_dut_b (
        .clk_ref(clk_ref), .rst(rst), .start(start), .abort(abort),
        .cfg_nblocks(cfg_nblocks[1:0]), .src_valid(src_valid), .src_data(src_data),
        .src_ready(b_src_ready), .pipe_ready(pipe_ready), .pipe_load(b_load),
        .pipe_enable(b_en), .pipe_valid(b_valid), .pipe_data(b_data), .busy(b_busy),
        .done(b_done), .underrun(b_und), .bit_cnt(b_bit), .blk_cnt(b_blk),
        .state_dbg(b_state)
    );

    logic       sel = 1'b0;
    logic       s_src_ready, s_load, s_en, s_valid, s_data, s_busy, s_done, s_und;
    logic [6:0] s_bit;
    logic [7:0] s_blk;
    logic [2:0] s_state;

    always_comb begin
        if (sel) begin
            s_src_ready = b_src_ready; s_load = b_load; s_en = b_en; s_valid = b_valid;
            s_data = b_data; s_busy = b_busy; s_done = b_done; s_und = b_und;
            s_bit = b_bit; s_blk = {6'd0, b_blk}; s_state = b_state;
        end else begin
            s_src_ready = a_src_ready; s_load = a_load; s_en = a_en; s_valid = a_valid;
            s_data = a_data; s_busy = a_busy; s_done = a_done; s_und = a_und;
            s_bit = a_bit; s_blk = a_blk; s_state = a_state;
        end
    end

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ptr, n_load, n_en, n_done, first_en, last_en, done_cyc;
    int         en_blk, en_at_load, viol, busy_after_done;
    logic [7:0] blk_at_done, prev_blk;
    logic       und_at_done, busy_at_done;
    int         load_q[$];
    int         blk_en_q[$];
    logic [7:0] blk_seq[$];
    logic [0:0] exp_q[$];
    logic       pl [1024];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic monitor();
        logic [0:0] e;
        if (s_en !== s_valid) viol++;
        if (!s_valid && s_data) viol++;
        if (s_load) begin
            if (n_load > 0) blk_en_q.push_back(en_blk);
            load_q.push_back(cyc);
            n_load++;
            en_blk = 0;
            if (s_en) en_at_load++;
        end
        if (s_en) begin
            if (n_en == 0) first_en = cyc;
            last_en = cyc;
            n_en++;
            en_blk++;
        end
        if (s_valid) begin
            if (exp_q.size() == 0) check("sb_empty_pop", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                check("pipe_data", s_data, e);
            end
        end
        if (n_done > 0 && cyc == done_cyc + 1) busy_after_done = s_busy;
        if (s_done) begin
            n_done++;
            done_cyc = cyc;
            blk_at_done = s_blk;
            und_at_done = s_und;
            busy_at_done = s_busy;
            blk_en_q.push_back(en_blk);
        end
        if (s_blk != prev_blk) begin
            blk_seq.push_back(s_blk);
            prev_blk = s_blk;
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic tick();
        logic hs;
        src_data = pl[ptr % 1024];
        #1;
        hs = src_valid && s_src_ready && !abort && !rst;
        if (hs) begin
            exp_q.push_back(src_data);
            ptr++;
        end
        @(posedge clk_ref);
        @(negedge clk_ref);
        cyc++;
        monitor();
    endtask

    task automatic clr_stats();
        ptr = 0; n_load = 0; n_en = 0; n_done = 0; first_en = 0; last_en = 0;
        done_cyc = 0; en_blk = 0; en_at_load = 0; viol = 0; busy_after_done = -1;
        blk_at_done = 8'd0; und_at_done = 1'b0; busy_at_done = 1'b0;
        prev_blk = s_blk;
        load_q.delete(); blk_en_q.delete(); blk_seq.delete(); exp_q.delete();
        for (int i = 0; i < 1024; i++) pl[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; pipe_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] nblk);
        cfg_nblocks = nblk;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_burst(input int budget, input int stall_at, input int stall_len,
                             input int starve_at, input int starve_len);
        int stall_left = stall_len;
        int starve_left = starve_len;
        int n = 0;
        while (n_done == 0 && n < budget) begin
            pipe_ready = 1'b1;
            src_valid = 1'b1;
            if (ptr == stall_at && stall_left > 0) begin
                pipe_ready = 1'b0;
                stall_left--;
                #1;
                check("stall_src_ready", s_src_ready, 0);
                check("stall_bit_cnt", s_bit, stall_at);
                check("stall_underrun", s_und, 0);
            end
            if (ptr == starve_at && starve_left > 0) begin
                src_valid = 1'b0;
                starve_left--;
            end
            tick();
            n++;
        end
        check("done_seen", n_done, 1);
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] pay;
        int          n;
        int          exp_seq[5];
        exp_seq = '{1, 2, 3, 0, 1};
        pay = 96'hACBCD2114DAE1577C6DBF4C9;

        @(negedge clk_ref);
        clr_stats();
        do_reset();
        check("rst_state", a_state, 0);
        check("rst_load", a_load, 0);
        check("rst_enable", a_en, 0);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_underrun", a_und, 0);
        check("rst_bit_cnt", a_bit, 0);
        check("rst_blk_cnt", a_blk, 0);
        check("rst_src_ready", a_src_ready, 0);
        check("rst_b_state", b_state, 0);

        // Single block, known payload MSB-first.
        sel = 1'b0;
        clr_stats();
        for (int i = 0; i < 96; i++) pl[i] = pay[95-i];
        start_burst(8'd1);
        run_burst(400, -1, 0, -1, 0);
        check("t1_loads", n_load, 1);
        check("t1_enables", n_en, 96);
        check("t1_load_to_en", first_en - load_q[0], 1);
        check("t1_en_span", last_en - first_en, 95);
        check("t1_done_after_last", done_cyc - last_en, 1);
        check("t1_blk_at_done", blk_at_done, 1);
        check("t1_busy_at_done", busy_at_done, 1);
        check("t1_busy_after_done", busy_after_done, 0);
        check("t1_sb_left", exp_q.size(), 0);
        check("t1_strobe_viol", viol, 0);

        // Three blocks with a 2-cycle gap.
        do_reset();
        sel = 1'b1;
        clr_stats();
        start_burst(8'd3);
        run_burst(600, -1, 0, -1, 0);
        check("t2_loads", n_load, 3);
        check("t2_spacing01", load_q[1] - load_q[0], 99);
        check("t2_spacing12", load_q[2] - load_q[1], 99);
        for (int i = 0; i < 3; i++) check("t2_blk_enables", blk_en_q[i], 96);
        check("t2_en_at_load", en_at_load, 0);
        check("t2_dones", n_done, 1);
        check("t2_blk_at_done", blk_at_done, 3);
        check("t2_sb_left", exp_q.size(), 0);
        check("t2_strobe_viol", viol, 0);

        // Backpressure: 5 stall cycles at bit 40 of the first block.
        do_reset();
        sel = 1'b0;
        clr_stats();
        start_burst(8'd2);
        run_burst(600, 40, 5, -1, 0);
        check("t3_spacing", load_q[1] - load_q[0], 102);
        check("t3_enables", n_en, 192);
        check("t3_underrun", und_at_done, 0);
        check("t3_blk_at_done", blk_at_done, 2);
        check("t3_sb_left", exp_q.size(), 0);

        // Underrun: source starves 3 cycles at bit 10.
        do_reset();
        clr_stats();
        start_burst(8'd1);
        run_burst(400, -1, 0, 10, 3);
        check("t4_underrun_at_done", und_at_done, 1);
        check("t4_enables", n_en, 96);
        check("t4_en_span", last_en - first_en, 98);
        check("t4_sb_left", exp_q.size(), 0);
        check("t4_underrun_held", s_und, 1);
        clr_stats();
        start_burst(8'd1);
        check("t4_underrun_cleared", s_und, 0);
        run_burst(400, -1, 0, -1, 0);
        check("t4b_underrun", und_at_done, 0);
        check("t4b_enables", n_en, 96);

        // Abort at bit 50 of block 2, start asserted on the same edge.
        do_reset();
        clr_stats();
        start_burst(8'd4);
        n = 0;
        pipe_ready = 1'b1;
        src_valid = 1'b1;
        while (ptr < 146 && n < 600) begin
            tick();
            n++;
        end
        check("t5_reach_bit", ptr, 146);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t5_state_idle", s_state, 0);
        check("t5_enable", s_en, 0);
        check("t5_valid", s_valid, 0);
        check("t5_data", s_data, 0);
        check("t5_load", s_load, 0);
        check("t5_bit_cnt", s_bit, 0);
        check("t5_blk_cnt", s_blk, 1);
        repeat (4) tick();
        check("t5_still_idle", s_state, 0);
        check("t5_busy", s_busy, 0);
        check("t5_no_done", n_done, 0);
        check("t5_no_new_load", n_load, 2);
        check("t5_sb_left", exp_q.size(), 0);

        // Continuous mode on the 2-bit counter instance.
        do_reset();
        sel = 1'b1;
        clr_stats();
        start_burst(8'd0);
        n = 0;
        pipe_ready = 1'b1;
        src_valid = 1'b1;
        while (blk_seq.size() < 5 && n < 800) begin
            tick();
            n++;
        end
        check("t6_blk_changes", blk_seq.size(), 5);
        for (int i = 0; i < 5; i++) check("t6_blk_seq", blk_seq[i], exp_seq[i]);
        check("t6_no_done", n_done, 0);
        check("t6_busy", s_busy, 1);
        src_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("t6_busy_after_abort", s_busy, 0);
        check("t6_state_idle", s_state, 0);
        check("t6_blk_hold", s_blk, 1);
        check("t6_strobe_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
